// File: rtl/ibex_fp_pkg.sv
// Shared FPU sequencing types and rounding-mode encodings.
//   fpu_class_e     : latency class of an FPU instruction
//   fpu_seq_state_e : states of the FPU issue/complete sequencer
//   RNE..DYN        : RISC-V rounding-mode field encodings
package ibex_fp_pkg;

  typedef enum logic [1:0] {
    SINGLE  = 2'd0,
    ADDMUL  = 2'd1,
    FMA     = 2'd2,
    DIVSQRT = 2'd3
  } fpu_class_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fpu_seq_state_e;

  localparam logic [2:0] RNE = 3'b000;
  localparam logic [2:0] RTZ = 3'b001;
  localparam logic [2:0] RDN = 3'b010;
  localparam logic [2:0] RUP = 3'b011;
  localparam logic [2:0] RMM = 3'b100;
  localparam logic [2:0] DYN = 3'b111;

endpackage

// File: rtl/ibex_fpu_seq.sv
// FPU operation sequencer: accepts one FPU request at a time from ID,
// resolves the rounding mode, pulses the datapath start, counts the
// class latency and presents the result to ID until it is taken.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   req_i, op_class_i   request and its latency class
//   rnd_mode_i, frm_i   instruction rounding field, CSR dynamic mode
//   flush_i             kill in-flight operation / block accept
//   ready_id_i          ID takes the result this cycle
//   ready_o             can accept (IDLE only)
//   start_o             one-cycle datapath start
//   operand_we_o        capture operands
//   rnd_mode_o          resolved rounding mode
//   result_we_o         capture datapath result
//   valid_o, illegal_o  result valid / illegal rounding mode
//   busy_o              operation in flight
module ibex_fpu_seq
  import ibex_fp_pkg::*;
#(
  parameter int unsigned LatAddMul  = 2,
  parameter int unsigned LatFma     = 3,
  parameter int unsigned LatDivSqrt = 12
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_i,
  input  fpu_class_e op_class_i,
  input  logic [2:0] rnd_mode_i,
  input  logic [2:0] frm_i,
  input  logic       flush_i,
  input  logic       ready_id_i,
  output logic       ready_o,
  output logic       start_o,
  output logic       operand_we_o,
  output logic [2:0] rnd_mode_o,
  output logic       result_we_o,
  output logic       valid_o,
  output logic       illegal_o,
  output logic       busy_o
);

  if (LatAddMul < 1 || LatAddMul > 31 || LatFma < 1 || LatFma > 31 ||
      LatDivSqrt < 1 || LatDivSqrt > 31) begin : gen_bad_latency
    $error("ibex_fpu_seq: latency parameters must lie in 1..31");
  end

  // Counter is loaded with latency-1 so that result_we_o lands exactly L
  // cycles after accept (one cycle is spent entering BUSY).
  localparam logic [4:0] CntAddMul  = 5'(LatAddMul - 1);
  localparam logic [4:0] CntFma     = 5'(LatFma - 1);
  localparam logic [4:0] CntDivSqrt = 5'(LatDivSqrt - 1);

  fpu_seq_state_e state_q, state_d;
  logic [4:0]     cnt_q, cnt_d;
  logic [2:0]     mode_q, mode_d;
  logic [2:0]     rm_res;
  logic           rm_ill;

  function automatic logic [2:0] resolve_rm(logic [2:0] rm, logic [2:0] frm);
    return (rm == DYN) ? frm : rm;
  endfunction

  function automatic logic is_illegal_rm(logic [2:0] rm);
    return (rm == 3'b101) || (rm == 3'b110);
  endfunction

  function automatic logic [4:0] class_cnt(fpu_class_e cls);
    case (cls)
      ADDMUL:  return CntAddMul;
      FMA:     return CntFma;
      DIVSQRT: return CntDivSqrt;
      default: return 5'd0;
    endcase
  endfunction

  assign rm_res = resolve_rm(rnd_mode_i, frm_i);
  assign rm_ill = is_illegal_rm(rm_res);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      mode_q  <= 3'b000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  // Every output is forced low while rst_i is high, so an operation hit by
  // reset never produces result_we_o or valid_o.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mode_d       = mode_q;
    ready_o      = 1'b0;
    start_o      = 1'b0;
    operand_we_o = 1'b0;
    rnd_mode_o   = 3'b000;
    result_we_o  = 1'b0;
    valid_o      = 1'b0;
    illegal_o    = 1'b0;
    busy_o       = 1'b0;
    if (!rst_i) begin
      case (state_q)
        IDLE: begin
          ready_o    = 1'b1;
          rnd_mode_o = rm_res;
          if (req_i && !flush_i) begin
            if (rm_ill) begin
              valid_o   = 1'b1;
              illegal_o = 1'b1;
            end else if (op_class_i == SINGLE) begin
              operand_we_o = 1'b1;
              valid_o      = 1'b1;
            end else begin
              operand_we_o = 1'b1;
              start_o      = 1'b1;
              cnt_d        = class_cnt(op_class_i);
              mode_d       = rm_res;
              state_d      = BUSY;
            end
          end
        end
        BUSY: begin
          busy_o     = 1'b1;
          rnd_mode_o = mode_q;
          if (flush_i) begin
            state_d = IDLE;
          end else if (cnt_q == 5'd0) begin
            result_we_o = 1'b1;
            state_d     = DONE;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
        DONE: begin
          busy_o     = 1'b1;
          rnd_mode_o = mode_q;
          if (flush_i) begin
            state_d = IDLE;
          end else begin
            valid_o = 1'b1;
            // Leaving on ready_id_i makes ready_o rise only next cycle.
            if (ready_id_i) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ibex_fpu_seq.sv
// Bench for ibex_fpu_seq: directed scenarios followed by randomized
// requests, each checked cycle by cycle against expectations derived from
// the operation's class latency, resolved rounding mode, ready and flush.
module tb_ibex_fpu_seq;
  import ibex_fp_pkg::*;

  logic       clk = 1'b0;
  logic       rst_i, req_i, flush_i, ready_id_i;
  fpu_class_e op_class_i;
  logic [2:0] rnd_mode_i, frm_i;
  logic       ready_o, start_o, operand_we_o, result_we_o;
  logic       valid_o, illegal_o, busy_o;
  logic [2:0] rnd_mode_o;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int cyc    = 0;

  ibex_fpu_seq dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .op_class_i  (op_class_i),
    .rnd_mode_i  (rnd_mode_i),
    .frm_i       (frm_i),
    .flush_i     (flush_i),
    .ready_id_i  (ready_id_i),
    .ready_o     (ready_o),
    .start_o     (start_o),
    .operand_we_o(operand_we_o),
    .rnd_mode_o  (rnd_mode_o),
    .result_we_o (result_we_o),
    .valid_o     (valid_o),
    .illegal_o   (illegal_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(fpu_class_e c);
    case (c)
      ADDMUL:  return 2;
      FMA:     return 3;
      DIVSQRT: return 12;
      default: return 0;
    endcase
  endfunction

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_outs(input string tag, input logic rdy, input logic st,
                             input logic owe, input logic [2:0] rm, input logic rwe,
                             input logic vld, input logic ill, input logic bsy);
    check({tag, ".ready"},      {7'd0, ready_o},      {7'd0, rdy});
    check({tag, ".start"},      {7'd0, start_o},      {7'd0, st});
    check({tag, ".operand_we"}, {7'd0, operand_we_o}, {7'd0, owe});
    check({tag, ".rnd_mode"},   {5'd0, rnd_mode_o},   {5'd0, rm});
    check({tag, ".result_we"},  {7'd0, result_we_o},  {7'd0, rwe});
    check({tag, ".valid"},      {7'd0, valid_o},      {7'd0, vld});
    check({tag, ".illegal"},    {7'd0, illegal_o},    {7'd0, ill});
    check({tag, ".busy"},       {7'd0, busy_o},       {7'd0, bsy});
  endtask

  // Issue one request and follow it to completion. rdly: cycles valid_o is
  // left waiting before ready_id_i; flush_at: cycle offset of flush (0=none).
  task automatic run_op(input string tag, input fpu_class_e cls, input logic [2:0] rm,
                        input logic [2:0] frm, input int rdly, input int flush_at);
    logic [2:0] res;
    logic       ill, rdy, fl;
    int         lat;
    bit         imm;
    res = (rm == 3'b111) ? frm : rm;
    ill = (res == 3'b101) || (res == 3'b110);
    lat = lat_of(cls);
    imm = ill || (cls == SINGLE);
    req_i = 1'b1; op_class_i = cls; rnd_mode_i = rm; frm_i = frm;
    ready_id_i = 1'b0; flush_i = 1'b0;
    sample;
    expect_outs({tag, ".acc"}, 1'b1, !imm, !ill, res, 1'b0, imm, ill, 1'b0);
    if (!imm) begin
      for (int k = 1; k <= lat + rdly + 2; k++) begin
        next_cycle;
        req_i = 1'b0;
        rdy = (k >= lat + 1 + rdly);
        fl  = (k == flush_at);
        ready_id_i = rdy;
        flush_i = fl;
        sample;
        expect_outs({tag, $sformatf(".k%0d", k)}, 1'b0, 1'b0, 1'b0, res,
                    (k == lat) && !fl, (k > lat) && !fl, 1'b0, 1'b1);
        if (fl || (k > lat && rdy)) break;
      end
    end
    next_cycle;
    req_i = 1'b0; ready_id_i = 1'b0; flush_i = 1'b0;
    sample;
    expect_outs({tag, ".after"}, 1'b1, 1'b0, 1'b0, res, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         seen;
    fpu_class_e rc;
    logic [2:0] rrm, rfrm;
    int         rdly, rfl;

    // Reset with a request pending: everything must stay low.
    rst_i = 1'b1; req_i = 1'b1; op_class_i = ADDMUL; rnd_mode_i = RDN; frm_i = RNE;
    flush_i = 1'b0; ready_id_i = 1'b0;
    next_cycle;
    sample;
    expect_outs("reset", 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle;
    rst_i = 1'b0; req_i = 1'b0;
    sample;
    expect_outs("post_reset", 1'b1, 1'b0, 1'b0, RDN, 1'b0, 1'b0, 1'b0, 1'b0);

    // Default ADDMUL accepted at cycle 10.
    while (cyc < 10) next_cycle;
    run_op("addmul_t10", ADDMUL, RNE, RNE, 0, 0);

    // DIVSQRT with ID stalling 5 cycles after valid.
    next_cycle;
    run_op("divsqrt_stall", DIVSQRT, RUP, RNE, 5, 0);

    // Dynamic mode resolving to an illegal value.
    next_cycle;
    run_op("illegal_dyn", FMA, 3'b111, 3'b110, 0, 0);
    next_cycle;
    run_op("illegal_101", ADDMUL, 3'b101, RNE, 0, 0);

    // FMA flushed two cycles after accept.
    next_cycle;
    run_op("fma_flush", FMA, RMM, RNE, 0, 2);

    // FMA flushed while waiting in DONE.
    next_cycle;
    run_op("fma_flush_done", FMA, RTZ, RNE, 3, 5);

    // SINGLE with dynamic mode.
    next_cycle;
    run_op("single_dyn", SINGLE, 3'b111, RTZ, 0, 0);

    // flush_i in IDLE blocks accept.
    next_cycle;
    req_i = 1'b1; op_class_i = DIVSQRT; rnd_mode_i = RNE; flush_i = 1'b1;
    sample;
    expect_outs("idle_flush", 1'b1, 1'b0, 1'b0, RNE, 1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle;
    req_i = 1'b0; flush_i = 1'b0;
    sample;
    expect_outs("idle_flush.next", 1'b1, 1'b0, 1'b0, RNE, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset during BUSY of DIVSQRT discards the operation.
    next_cycle;
    req_i = 1'b1; op_class_i = DIVSQRT; rnd_mode_i = RNE; frm_i = RNE;
    sample;
    check("rst_busy.start", {7'd0, start_o}, 8'd1);
    for (int i = 0; i < 4; i++) begin
      next_cycle;
      req_i = 1'b0;
    end
    rst_i = 1'b1;
    sample;
    expect_outs("rst_busy.during", 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle;
    rst_i = 1'b0;
    sample;
    expect_outs("rst_busy.next", 1'b1, 1'b0, 1'b0, RNE, 1'b0, 1'b0, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      next_cycle;
      sample;
      if (valid_o || result_we_o || busy_o) seen = 1'b1;
    end
    check("rst_busy.no_late_result", {7'd0, seen}, 8'd0);

    // Randomized requests.
    for (int n = 0; n < 30; n++) begin
      rc   = fpu_class_e'($urandom_range(0, 3));
      rrm  = 3'($urandom_range(0, 7));
      rfrm = 3'($urandom_range(0, 7));
      rdly = $urandom_range(0, 3);
      rfl  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, lat_of(rc) + 1 + rdly) : 0;
      for (int g = $urandom_range(0, 2); g > 0; g--) next_cycle;
      next_cycle;
      run_op($sformatf("rand%0d", n), rc, rrm, rfrm, rdly, rfl);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
